// File: rtl/esmu_322_pkg.sv
// params_e322: shared constants and trellis helpers for the esmu_322 survivor unit.
//   E322_W  path-metric width      E322_K  decoded bits per trellis step
//   E322_D  survivor depth         E322_NS trellis state count
//   pred_state(s', b)  predecessor of s' under survivor decision b
//   next_state(s, u)   successor of s under input u
package params_e322;

    localparam int unsigned E322_W  = 8;
    localparam int unsigned E322_K  = 2;
    localparam int unsigned E322_D  = 12;
    localparam int unsigned E322_NS = 8;

    function automatic logic [2:0] pred_state(input logic [2:0] s_next, input logic [1:0] b);
        return {b, s_next[2]};
    endfunction

    function automatic logic [2:0] next_state(input logic [2:0] s, input logic [1:0] u);
        return {s[0], u};
    endfunction

endpackage

// File: rtl/esmu_322_if.sv
// esmu_322_if: ACS-to-survivor-unit bus.
//   ae                  new trellis column present this cycle
//   acsN_ppm_in         new path metric for state N (unsigned, smaller is better)
//   acsN_Bx_in          survivor decision for state N
//   dec_out/dec_valid   decoded bits and their one-cycle strobe
//   best_state          state whose survivor produced dec_out
interface esmu_322_if #(
    parameter int unsigned W = params_e322::E322_W,
    parameter int unsigned K = params_e322::E322_K
);
    logic         ae;
    logic [W-1:0] acs0_ppm_in, acs1_ppm_in, acs2_ppm_in, acs3_ppm_in;
    logic [W-1:0] acs4_ppm_in, acs5_ppm_in, acs6_ppm_in, acs7_ppm_in;
    logic [K-1:0] acs0_Bx_in, acs1_Bx_in, acs2_Bx_in, acs3_Bx_in;
    logic [K-1:0] acs4_Bx_in, acs5_Bx_in, acs6_Bx_in, acs7_Bx_in;
    logic [K-1:0] dec_out;
    logic         dec_valid;
    logic [2:0]   best_state;

    modport master (
        output ae,
        output acs0_ppm_in, acs1_ppm_in, acs2_ppm_in, acs3_ppm_in,
        output acs4_ppm_in, acs5_ppm_in, acs6_ppm_in, acs7_ppm_in,
        output acs0_Bx_in, acs1_Bx_in, acs2_Bx_in, acs3_Bx_in,
        output acs4_Bx_in, acs5_Bx_in, acs6_Bx_in, acs7_Bx_in,
        input  dec_out, dec_valid, best_state
    );

    modport slave (
        input  ae,
        input  acs0_ppm_in, acs1_ppm_in, acs2_ppm_in, acs3_ppm_in,
        input  acs4_ppm_in, acs5_ppm_in, acs6_ppm_in, acs7_ppm_in,
        input  acs0_Bx_in, acs1_Bx_in, acs2_Bx_in, acs3_Bx_in,
        input  acs4_Bx_in, acs5_Bx_in, acs6_Bx_in, acs7_Bx_in,
        output dec_out, dec_valid, best_state
    );
endinterface

// File: rtl/esmu_322_emin8.sv
// emin8_322: combinational 8-way argmin over unsigned path metrics.
//   ppm[8]   path metrics          min_idx  index of the smallest metric
// Ties resolve to the lowest index: the lower-indexed operand sits on the left
// at every level and the right one wins only when strictly smaller.
module emin8_322 #(
    parameter int unsigned W = params_e322::E322_W
) (
    input  logic [W-1:0] ppm [8],
    output logic [2:0]   min_idx
);
    logic [W-1:0] l1_v [4];
    logic [2:0]   l1_i [4];
    logic [W-1:0] l2_v [2];
    logic [2:0]   l2_i [2];

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (ppm[2*i+1] < ppm[2*i]) begin
                l1_v[i] = ppm[2*i+1];
                l1_i[i] = 3'(2*i+1);
            end else begin
                l1_v[i] = ppm[2*i];
                l1_i[i] = 3'(2*i);
            end
        end
        for (int unsigned i = 0; i < 2; i++) begin
            if (l1_v[2*i+1] < l1_v[2*i]) begin
                l2_v[i] = l1_v[2*i+1];
                l2_i[i] = l1_i[2*i+1];
            end else begin
                l2_v[i] = l1_v[2*i];
                l2_i[i] = l1_i[2*i];
            end
        end
        min_idx = (l2_v[1] < l2_v[0]) ? l2_i[1] : l2_i[0];
    end
endmodule

// File: rtl/esmu_322.sv
// esmu_322: register-exchange survivor memory for the 8-state (3,2,2) trellis.
//   clock, reset  single clock, synchronous active-high reset
//   bus (slave)   ae/ppm/Bx column in; dec_out, dec_valid, best_state out
// Stage 1 (on ae) shifts all 8 survivors and latches the best index plus a
// "window full" flag; stage 2 (next edge) emits the oldest entry of that survivor.
module esmu_322
    import params_e322::*;
#(
    parameter int unsigned W = E322_W,
    parameter int unsigned K = E322_K,
    parameter int unsigned D = E322_D
) (
    input  logic      clock,
    input  logic      reset,
    esmu_322_if.slave bus
);
    localparam int unsigned FW = $clog2(D + 1);

    logic [W-1:0]  ppm [E322_NS];
    logic [K-1:0]  bx  [E322_NS];
    logic [2:0]    min_idx;

    logic [K-1:0]  path_q [E322_NS][D];
    logic [K-1:0]  path_d [E322_NS][D];
    logic [FW-1:0] fill_q, fill_d, fill_after;
    logic [2:0]    best_q, best_d;
    logic          v1_q, v1_d;
    logic [K-1:0]  dec_out_q, dec_out_d;
    logic [2:0]    best_state_q, best_state_d;
    logic          dec_valid_q, dec_valid_d;
    logic [2:0]    s;

    always_comb begin
        ppm[0] = bus.acs0_ppm_in;  ppm[1] = bus.acs1_ppm_in;
        ppm[2] = bus.acs2_ppm_in;  ppm[3] = bus.acs3_ppm_in;
        ppm[4] = bus.acs4_ppm_in;  ppm[5] = bus.acs5_ppm_in;
        ppm[6] = bus.acs6_ppm_in;  ppm[7] = bus.acs7_ppm_in;
        bx[0]  = bus.acs0_Bx_in;   bx[1]  = bus.acs1_Bx_in;
        bx[2]  = bus.acs2_Bx_in;   bx[3]  = bus.acs3_Bx_in;
        bx[4]  = bus.acs4_Bx_in;   bx[5]  = bus.acs5_Bx_in;
        bx[6]  = bus.acs6_Bx_in;   bx[7]  = bus.acs7_Bx_in;
    end

    emin8_322 #(.W(W)) u_emin8 (
        .ppm     (ppm),
        .min_idx (min_idx)
    );

    always_comb begin
        path_d     = path_q;
        fill_d     = fill_q;
        best_d     = best_q;
        v1_d       = 1'b0;
        s          = '0;
        fill_after = (fill_q == FW'(D)) ? fill_q : fill_q + FW'(1);

        if (bus.ae) begin
            for (int unsigned ns = 0; ns < E322_NS; ns++) begin
                s = 3'(ns);
                path_d[ns][0] = K'(s[1:0]);
                for (int unsigned i = 1; i < D; i++) begin
                    path_d[ns][i] = path_q[pred_state(s, bx[ns])][i-1];
                end
            end
            fill_d = fill_after;
            best_d = min_idx;
            // fill saturates at D, so equality is the ">= D" condition
            v1_d   = (fill_after == FW'(D));
        end

        // Stage 2 reads pre-update survivors; outputs hold while nothing is valid.
        dec_valid_d  = v1_q;
        dec_out_d    = dec_out_q;
        best_state_d = best_state_q;
        if (v1_q) begin
            dec_out_d    = path_q[best_q][D-1];
            best_state_d = best_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned ns = 0; ns < E322_NS; ns++) begin
                for (int unsigned i = 0; i < D; i++) begin
                    path_q[ns][i] <= '0;
                end
            end
            fill_q       <= '0;
            best_q       <= '0;
            v1_q         <= 1'b0;
            dec_out_q    <= '0;
            best_state_q <= '0;
            dec_valid_q  <= 1'b0;
        end else begin
            path_q       <= path_d;
            fill_q       <= fill_d;
            best_q       <= best_d;
            v1_q         <= v1_d;
            dec_out_q    <= dec_out_d;
            best_state_q <= best_state_d;
            dec_valid_q  <= dec_valid_d;
        end
    end

    assign bus.dec_out    = dec_out_q;
    assign bus.dec_valid  = dec_valid_q;
    assign bus.best_state = best_state_q;
endmodule
